// File: rtl/sync_fifo_thresh.sv
// ============================================================================
// sync_fifo_thresh : single-clock show-ahead FIFO, any depth, runtime
// almost-full/empty thresholds, flush, sticky error flags.
// Optional peak-occupancy watermark enabled by macro SYNC_FIFO_PEAK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_thresh #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      count,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_W-1:0]      peak_count
);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Explicit wrap so non-power-of-2 depths never address past the last entry.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
  endfunction

  assign wr_ready     = (count != FULL_CNT);
  assign rd_valid     = (count != '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign rd_data      = mem[rd_ptr];

  // Flush swallows any request made in the same cycle.
  assign wr_acc = wr_en & wr_ready & ~flush;
  assign rd_acc = rd_en & rd_valid & ~flush;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  // Sticky flags: a new error event in the clearing cycle takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ready && !flush) overflow <= 1'b1;
      else if (err_clr)                 overflow <= 1'b0;
      if (rd_en && !rd_valid && !flush) underflow <= 1'b1;
      else if (err_clr)                 underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      peak_count <= '0;
    end else if (count_next > peak_count) begin
      peak_count <= count_next;
    end
  end
`else
  assign peak_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_thresh.sv
// ============================================================================
// tb_sync_fifo_thresh : scenario tasks plus random traffic against a queue
// model of the FIFO rules. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_thresh;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, flush, wr_en, rd_en, err_clr;
  logic [DW-1:0]    wr_data;
  logic             wr_ready, rd_valid, almost_full, almost_empty;
  logic             overflow, underflow;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] count, af_thresh, ae_thresh, peak_count;

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf;
  int            m_peak;

  sync_fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
    .peak_count(peak_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_peak();
`ifdef SYNC_FIFO_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  // One clock: model consumes the inputs presented before the edge, outputs
  // are then sampled 1 time unit after the edge.
  task automatic tick();
    bit w, r, f, c, rs;
    bit full, empty;
    logic [DW-1:0] d;
    w = wr_en; r = rd_en; f = flush; c = err_clr; rs = rst_n; d = wr_data;
    @(posedge clk);
    if (!rs) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (c) begin m_ovf = 0; m_udf = 0; end
      if (f) begin
        q.delete(); m_peak = 0;
      end else begin
        if (w && full)  m_ovf = 1;
        if (r && empty) m_udf = 1;
        if (r && !empty) void'(q.pop_front());
        if (w && !full)  q.push_back(d);
        if (q.size() > m_peak) m_peak = q.size();
      end
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  task automatic do_flush();
    idle(); flush = 1; tick(); flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); wr_data = '0; af_thresh = '0; ae_thresh = '0;
    tick(); tick();
    rst_n = 1;
    tests++; if (count !== 0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
    tests++; if (almost_full !== 1'b1) begin fails++; $display("FAIL reset_af_thr0 got %b exp 1", almost_full); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_err got %b%b exp 00", overflow, underflow); end
    tests++; if (peak_count !== 0) begin fails++; $display("FAIL reset_peak got %0d exp 0", peak_count); end
    af_thresh = 4; #1;
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_af_thr4 got %b exp 0", almost_full); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_data = DW'(8'hA0 + i);
      tick();
      tests++; if (count !== CNT_W'(i + 1)) begin fails++; $display("FAIL b2b_count[%0d] got %0d exp %0d", i, count, i + 1); end
      tests++; if (wr_ready !== (i + 1 != DEPTH)) begin fails++; $display("FAIL b2b_wr_ready[%0d] got %b exp %b", i, wr_ready, i + 1 != DEPTH); end
      tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0) begin fails++; $display("FAIL b2b_head[%0d] got %b/%h exp 1/a0", i, rd_valid, rd_data); end
    end
    idle();
  endtask

  task automatic test_full_overflow();
    wr_en = 1; rd_en = 1; wr_data = 8'hEE;
    tick(); idle();
    tests++; if (count !== 5) begin fails++; $display("FAIL full_rw_count got %0d exp 5", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_rw_ovf got %b exp 1", overflow); end
    tests++; if (rd_data !== 8'hA1) begin fails++; $display("FAIL full_rw_head got %h exp a1", rd_data); end
    err_clr = 1; tick(); idle();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL err_clr_ovf got %b exp 0", overflow); end
    wr_en = 1; wr_data = 8'h55; tick();              // refill to full
    err_clr = 1; wr_en = 1; tick(); idle();          // clear and set together
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL clr_vs_set_ovf got %b exp 1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      tests++; if (rd_data !== q[0]) begin fails++; $display("FAIL drain_data[%0d] got %h exp %h", i, rd_data, q[0]); end
      rd_en = 1; tick(); idle();
    end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b exp 0", rd_valid); end
    err_clr = 1; tick(); idle();
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; wr_data = DW'(i); tick(); idle();
      tests++; if (count !== 1 || rd_data !== DW'(i)) begin fails++; $display("FAIL wrap_w[%0d] got cnt %0d data %h exp 1/%h", i, count, rd_data, i); end
      rd_en = 1; tick(); idle();
      tests++; if (count !== 0) begin fails++; $display("FAIL wrap_r[%0d] got cnt %0d exp 0", i, count); end
    end
  endtask

  task automatic test_thresholds();
    af_thresh = 4; ae_thresh = 1;
    for (int n = 0; n <= 5; n++) begin
      tests++; if (almost_empty !== (n <= 1)) begin fails++; $display("FAIL thr_ae[%0d] got %b exp %b", n, almost_empty, n <= 1); end
      tests++; if (almost_full !== (n >= 4)) begin fails++; $display("FAIL thr_af[%0d] got %b exp %b", n, almost_full, n >= 4); end
      if (n < 5) begin wr_en = 1; wr_data = DW'(n); tick(); idle(); end
    end
    af_thresh = 6; #1;
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL thr_af_live got %b exp 0", almost_full); end
    do_flush();
  endtask

  task automatic test_flush();
    bit ovf_before;
    for (int i = 0; i < 3; i++) begin wr_en = 1; wr_data = DW'(8'h30 + i); tick(); end
    idle();
    ovf_before = overflow;
    flush = 1; wr_en = 1; wr_data = 8'hFF; tick(); idle();
    tests++; if (count !== 0 || rd_valid !== 1'b0) begin fails++; $display("FAIL flush_state got cnt %0d valid %b exp 0/0", count, rd_valid); end
    tests++; if (overflow !== ovf_before) begin fails++; $display("FAIL flush_ovf got %b exp %b", overflow, ovf_before); end
    rd_en = 1; tick(); idle();
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL flush_udf got %b exp 1", underflow); end
    wr_en = 1; wr_data = 8'h77; tick(); idle();
    tests++; if (count !== 1 || rd_data !== 8'h77) begin fails++; $display("FAIL flush_nostore got cnt %0d data %h exp 1/77", count, rd_data); end
    err_clr = 1; tick(); idle();
    do_flush();
  endtask

  task automatic test_peak();
    for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = DW'(i); tick(); end
    idle();
    for (int i = 0; i < 4; i++) begin rd_en = 1; tick(); end
    idle();
    tests++; if (peak_count !== CNT_W'(exp_peak()) || exp_peak() != (q.size() == 1 ? 5 : -1) && exp_peak() != 0)
      begin fails++; $display("FAIL peak_hold got %0d exp %0d", peak_count, exp_peak()); end
    do_flush();
    tests++; if (peak_count !== 0) begin fails++; $display("FAIL peak_flush got %0d exp 0", peak_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 99) < 55);
      rd_en   = ($urandom_range(0, 99) < 45);
      flush   = ($urandom_range(0, 99) < 3);
      err_clr = ($urandom_range(0, 99) < 5);
      wr_data = DW'($urandom);
      if ($urandom_range(0, 9) == 0) af_thresh = CNT_W'($urandom_range(0, DEPTH + 1));
      if ($urandom_range(0, 9) == 0) ae_thresh = CNT_W'($urandom_range(0, DEPTH + 1));
      tick();
      tests++; if (count !== CNT_W'(q.size()) || rd_valid !== (q.size() != 0) || wr_ready !== (q.size() != DEPTH))
        begin fails++; $display("FAIL rnd_status[%0d] got cnt %0d v %b r %b exp cnt %0d", i, count, rd_valid, wr_ready, q.size()); end
      if (q.size() != 0) begin
        tests++; if (rd_data !== q[0]) begin fails++; $display("FAIL rnd_data[%0d] got %h exp %h", i, rd_data, q[0]); end
      end
      tests++; if (almost_full !== (q.size() >= int'(af_thresh)) || almost_empty !== (q.size() <= int'(ae_thresh)))
        begin fails++; $display("FAIL rnd_thr[%0d] got af %b ae %b cnt %0d", i, almost_full, almost_empty, q.size()); end
      tests++; if (overflow !== m_ovf || underflow !== m_udf)
        begin fails++; $display("FAIL rnd_err[%0d] got %b%b exp %b%b", i, overflow, underflow, m_ovf, m_udf); end
      tests++; if (peak_count !== CNT_W'(exp_peak()))
        begin fails++; $display("FAIL rnd_peak[%0d] got %0d exp %0d", i, peak_count, exp_peak()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_overflow();
    test_wrap();
    test_thresholds();
    test_flush();
    test_peak();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
